// File: rtl/prbs5_pkg.sv
// prbs5_pkg: shared state encoding and PRBS5 polynomial constants (x^5+x^2+1).
package prbs5_pkg;
    typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_t;
    localparam int PRBS5_LEN    = 5;
    localparam int TAP_A        = 2;
    localparam int TAP_B        = 4;
    localparam int PRBS5_PERIOD = 31;
endpackage

// File: rtl/prbs5_history.sv
// prbs5_history: 5-bit history of the received stream; predicts the next bit as hist[2]^hist[4].
module prbs5_history
    import prbs5_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sel_pred,
    input  logic din,
    output logic pred,
    output logic hist_zero
);
    logic [PRBS5_LEN-1:0] hist;
    assign pred      = hist[TAP_A] ^ hist[TAP_B];
    assign hist_zero = ~|hist;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            hist <= '0;
        else if (en)
            hist <= {hist[PRBS5_LEN-2:0], sel_pred ? pred : din};
endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising serial PRBS5 checker with flywheel lock and saturating error count.
// Define PRBS5_CHK_BITCNT_EN to add the bit_cnt port (beats checked while locked).
module prbs5_checker
    import prbs5_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int WIN      = 16,
    parameter int LOSS_THR = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS5_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] bit_cnt
`endif
);
    // Lock needs fewer correct predictions than one full sequence period.
    localparam int MATCH_W = $clog2(PRBS5_PERIOD + 1);
    localparam int WIN_W   = WIN > 1 ? $clog2(WIN) : 1;
    localparam int ERR_W   = $clog2(LOSS_THR + 1);

    state_t             state;
    logic [2:0]         fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [ERR_W-1:0]   win_err;
    logic [ERR_W-1:0]   win_err_nx;
    logic [CNT_W-1:0]   err_cnt_inc;
    logic               pred, hist_zero, err, chk, wrap, loss;

    prbs5_history u_hist (
        .clk      (clk),
        .reset    (reset),
        .en       (din_valid),
        .sel_pred (state == LOCKED),
        .din      (din),
        .pred     (pred),
        .hist_zero(hist_zero)
    );

    assign err         = din ^ pred;
    assign chk         = din_valid && state == LOCKED;
    assign win_err_nx  = win_err + ERR_W'(err);
    assign loss        = win_err_nx == ERR_W'(LOSS_THR);
    assign wrap        = win_cnt == WIN_W'(WIN - 1);
    assign err_cnt_inc = &err_cnt ? err_cnt : err_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= chk && err;
            if (chk && err)
                err_cnt <= clr_cnt ? CNT_W'(1) : err_cnt_inc;
            else if (clr_cnt)
                err_cnt <= '0;
            if (din_valid) begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt == 3'(PRBS5_LEN - 1) ? '0 : fill_cnt + 3'd1;
                        if (fill_cnt == 3'(PRBS5_LEN - 1)) begin
                            state     <= SYNC;
                            match_cnt <= '0;
                        end
                    end
                    SYNC: begin
                        if (!err && !hist_zero) begin
                            match_cnt <= match_cnt == MATCH_W'(LOCK_CNT - 1) ? '0 : match_cnt + MATCH_W'(1);
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_cnt <= '0;
                                win_err <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // The wrap beat's error is judged against the ending window before it clears.
                        if (loss) begin
                            state     <= FILL;
                            locked    <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            win_cnt <= wrap ? '0 : win_cnt + WIN_W'(1);
                            win_err <= wrap ? '0 : win_err_nx;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

`ifdef PRBS5_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bit_cnt <= '0;
        else if (clr_cnt)
            bit_cnt <= chk ? CNT_W'(1) : '0;
        else if (chk && !(&bit_cnt))
            bit_cnt <= bit_cnt + CNT_W'(1);
    end
`endif
endmodule
